// File: rtl/run_ctrl.sv
// Run controller: sequences core reset, counts run cycles, detects per-core PC self-loop halt and flags timeout.
// All outputs registered; no backpressure (start is ignored outside IDLE/DONE/TIMEOUT).
module run_ctrl #(
    parameter int NCORE      = 1,
    parameter int RST_CYCLES = 10,
    parameter int HALT_REP   = 4,
    parameter int MAX_CYCLES = 100000,
    parameter int CNT_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [NCORE-1:0]      i_pc_valid,
    input  logic [NCORE*32-1:0]   i_pc,
    output logic                  o_core_rst,
    output logic                  o_running,
    output logic [NCORE-1:0]      o_halted,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [CNT_W-1:0]      o_cycle_cnt
);

    localparam int REP_W = $clog2(HALT_REP);
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(HALT_REP - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_DONE, S_TIMEOUT} state_t;

    state_t                      r_state;
    logic [RC_W-1:0]             r_rst_cnt;
    logic [NCORE-1:0][31:0]      r_last_pc;
    logic [NCORE-1:0][REP_W-1:0] r_rep;

    logic [NCORE-1:0][REP_W-1:0] w_rep_nxt;
    logic [NCORE-1:0]            w_halted_nxt;
    logic                        w_at_limit;

    // Repeat count only moves on a valid sample; invalid cycles leave the streak intact.
    always_comb begin
        w_rep_nxt    = r_rep;
        w_halted_nxt = o_halted;
        for (int i = 0; i < NCORE; i++) begin
            if (i_pc_valid[i]) begin
                if (i_pc[32*i +: 32] == r_last_pc[i])
                    w_rep_nxt[i] = (r_rep[i] == REP_MAX) ? r_rep[i] : r_rep[i] + REP_W'(1);
                else
                    w_rep_nxt[i] = '0;
            end
            w_halted_nxt[i] = o_halted[i] | (w_rep_nxt[i] == REP_MAX);
        end
    end

    assign w_at_limit = (o_cycle_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_rst_cnt   <= '0;
            r_last_pc   <= '0;
            r_rep       <= '0;
            o_core_rst  <= 1'b1;
            o_running   <= 1'b0;
            o_halted    <= '0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
            o_cycle_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (i_start) begin
                        r_state     <= S_RST;
                        r_rst_cnt   <= '0;
                        r_last_pc   <= '0;
                        r_rep       <= '0;
                        o_core_rst  <= 1'b1;
                        o_running   <= 1'b0;
                        o_halted    <= '0;
                        o_done      <= 1'b0;
                        o_timeout   <= 1'b0;
                        o_cycle_cnt <= '0;
                    end
                end
                S_RST: begin
                    if (r_rst_cnt == RC_LAST) begin
                        r_state    <= S_RUN;
                        o_core_rst <= 1'b0;
                        o_running  <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RC_W'(1);
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NCORE; i++) begin
                        if (i_pc_valid[i])
                            r_last_pc[i] <= i_pc[32*i +: 32];
                    end
                    r_rep    <= w_rep_nxt;
                    o_halted <= w_halted_nxt;
                    if (o_cycle_cnt != '1)
                        o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
                    // A final halt landing on the limit edge still counts as a clean finish.
                    if ((&o_halted) || (w_at_limit && (&w_halted_nxt))) begin
                        r_state   <= S_DONE;
                        o_running <= 1'b0;
                        o_done    <= 1'b1;
                    end else if (w_at_limit) begin
                        r_state    <= S_TIMEOUT;
                        o_running  <= 1'b0;
                        o_timeout  <= 1'b1;
                        o_core_rst <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: randomized PC streams checked every cycle against a windowed-history reference model.
module tb_run_ctrl;

    localparam int NC   = 2;
    localparam int RSTC = 10;
    localparam int HREP = 4;
    localparam int MAXC = 64;
    localparam int CW   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [NC-1:0]     pc_valid = '0;
    logic [NC*32-1:0]  pc = '0;
    logic              core_rst, running, done, timeout;
    logic [NC-1:0]     halted;
    logic [CW-1:0]     cycle_cnt;

    run_ctrl #(.NCORE(NC), .RST_CYCLES(RSTC), .HALT_REP(HREP), .MAX_CYCLES(MAXC), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_pc_valid(pc_valid), .i_pc(pc),
        .o_core_rst(core_rst), .o_running(running), .o_halted(halted),
        .o_done(done), .o_timeout(timeout), .o_cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    wire [CW+5:0] dut_vec = {core_rst, running, halted, done, timeout, cycle_cnt};
    localparam logic [CW+5:0] RST_VEC = {1'b1, {(CW+5){1'b0}}};

    // Reference model: phase 0 idle, 1 reset, 2 run, 3 done, 4 timeout.
    int            m_ph = 0;
    int            m_rst_n = 0;
    logic [CW-1:0] m_cnt = '0;
    logic [NC-1:0] m_halt = '0;
    logic [31:0]   m_win [NC][HREP];
    int            m_len [NC];

    function automatic logic [CW+5:0] exp_vec();
        return {(m_ph == 0 || m_ph == 1 || m_ph == 4), (m_ph == 2), m_halt,
                (m_ph == 3), (m_ph == 4), m_cnt};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            m_len[i] = 1;
            m_win[i][HREP-1] = 32'h0;
        end
        m_cnt  = '0;
        m_halt = '0;
    endtask

    // A core is halted once its last HREP valid samples (seeded by a PC of 0) are identical.
    task automatic model_edge();
        logic all_before;
        logic [CW-1:0] old_cnt;
        if (!reset) begin
            m_ph = 0; m_rst_n = 0; model_clear();
        end else if (m_ph == 0 || m_ph == 3 || m_ph == 4) begin
            if (start) begin m_ph = 1; m_rst_n = 0; model_clear(); end
        end else if (m_ph == 1) begin
            m_rst_n++;
            if (m_rst_n == RSTC) m_ph = 2;
        end else begin
            all_before = &m_halt;
            for (int i = 0; i < NC; i++) begin
                if (pc_valid[i]) begin
                    for (int j = 0; j < HREP-1; j++) m_win[i][j] = m_win[i][j+1];
                    m_win[i][HREP-1] = pc[32*i +: 32];
                    if (m_len[i] < HREP) m_len[i]++;
                end
                if (m_len[i] == HREP) begin
                    logic same;
                    same = 1'b1;
                    for (int j = 0; j < HREP; j++) if (m_win[i][j] != m_win[i][0]) same = 1'b0;
                    if (same) m_halt[i] = 1'b1;
                end
            end
            old_cnt = m_cnt;
            if (m_cnt != '1) m_cnt++;
            if (all_before) m_ph = 3;
            else if (old_cnt == CW'(MAXC-1)) m_ph = (&m_halt) ? 3 : 4;
        end
    endtask

    task automatic run_cycle(input logic st, input logic [NC-1:0] v, input logic [NC*32-1:0] p);
        start = st; pc_valid = v; pc = p;
        @(posedge clk);
        model_edge();
        #1;
        start = 1'b0;
    endtask

    task automatic begin_run();
        reset = 1'b0; run_cycle(1'b0, '0, '0);
        reset = 1'b1; run_cycle(1'b1, '0, '0);
        repeat (RSTC) run_cycle(1'b0, '0, '0);
    endtask

    task automatic test_reset();
        int fall_at = 0;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b0, '0, '0);
            checks++;
            if (dut_vec !== RST_VEC) $display("FAIL reset_hold: got %h expected %h", dut_vec, RST_VEC);
            else passes++;
        end
        reset = 1'b1;
        run_cycle(1'b1, '0, '0);
        for (int k = 1; k <= 12; k++) begin
            run_cycle(1'b0, '0, '0);
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL reset_seq k=%0d: got %h expected %h", k, dut_vec, exp_vec());
            else passes++;
            if (fall_at == 0 && core_rst === 1'b0) fall_at = k;
        end
        checks++;
        if (fall_at !== 10) $display("FAIL core_rst_fall: got edge %0d expected edge 10", fall_at);
        else passes++;
        checks++;
        if (running !== 1'b1 || cycle_cnt !== CW'(2))
            $display("FAIL run_start: got running=%b cnt=%0d expected running=1 cnt=2", running, cycle_cnt);
        else passes++;
    endtask

    task automatic test_single_halt();
        logic [31:0] seq [7] = '{32'h3000, 32'h3004, 32'h3008, 32'h300c, 32'h300c, 32'h300c, 32'h300c};
        begin_run();
        for (int k = 1; k <= 11; k++) begin
            logic [31:0] p0;
            p0 = (k <= 7) ? seq[k-1] : 32'h300c;
            run_cycle(1'b0, 2'b11, {32'h0, p0});
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL single_halt k=%0d: got %h expected %h", k, dut_vec, exp_vec());
            else passes++;
            if (k == 7) begin
                checks++;
                if (halted !== 2'b11 || done !== 1'b0)
                    $display("FAIL halt_edge: got halted=%b done=%b expected halted=11 done=0", halted, done);
                else passes++;
            end
            if (k == 8 || k == 11) begin
                checks++;
                if (done !== 1'b1 || running !== 1'b0 || core_rst !== 1'b0 || cycle_cnt !== CW'(8))
                    $display("FAIL done_frozen k=%0d: got done=%b run=%b rst=%b cnt=%0d expected 1 0 0 8",
                             k, done, running, core_rst, cycle_cnt);
                else passes++;
            end
        end
    endtask

    task automatic test_two_cores();
        logic seen01 = 1'b0;
        begin_run();
        for (int k = 1; k <= 55; k++) begin
            logic [NC-1:0] v;
            logic [31:0] p [NC];
            for (int i = 0; i < NC; i++) begin
                int stop_k;
                stop_k = (i == 0) ? 16 : 44;
                if (k < stop_k) begin
                    v[i] = $urandom_range(0, 3) != 0;
                    p[i] = v[i] ? 32'h1000 + 32'(i * 256) + 32'(4 * k) : $urandom;
                end else begin
                    v[i] = (k % 3) != 0;
                    p[i] = v[i] ? 32'hC0DE_0000 + 32'(i) : $urandom;
                end
            end
            run_cycle(1'b0, v, {p[1], p[0]});
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL two_cores k=%0d: got %h expected %h", k, dut_vec, exp_vec());
            else passes++;
            if (halted === 2'b01) seen01 = 1'b1;
        end
        checks++;
        if (!seen01 || done !== 1'b1 || timeout !== 1'b0 || cycle_cnt !== CW'(50))
            $display("FAIL two_cores_end: got seen01=%b done=%b to=%b cnt=%0d expected 1 1 0 50",
                     seen01, done, timeout, cycle_cnt);
        else passes++;
    endtask

    task automatic test_timeout();
        begin_run();
        for (int k = 1; k <= 70; k++) begin
            logic [NC-1:0] v;
            v = NC'($urandom_range(0, 3));
            run_cycle(1'b0, v, {32'h2800 + 32'(4 * k), 32'h2000 + 32'(4 * k)});
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL timeout k=%0d: got %h expected %h", k, dut_vec, exp_vec());
            else passes++;
        end
        checks++;
        if (timeout !== 1'b1 || core_rst !== 1'b1 || cycle_cnt !== CW'(64) || done !== 1'b0)
            $display("FAIL timeout_end: got to=%b rst=%b cnt=%0d done=%b expected 1 1 64 0",
                     timeout, core_rst, cycle_cnt, done);
        else passes++;
    endtask

    task automatic test_halt_at_limit();
        begin_run();
        for (int k = 1; k <= 66; k++) begin
            logic [31:0] p0;
            p0 = (k <= 60) ? 32'h5000 + 32'(4 * k) : 32'h5FF0;
            run_cycle(1'b0, 2'b11, {32'h0, p0});
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL limit k=%0d: got %h expected %h", k, dut_vec, exp_vec());
            else passes++;
            if (k == 64) begin
                checks++;
                if (done !== 1'b1 || timeout !== 1'b0 || cycle_cnt !== CW'(64))
                    $display("FAIL limit_tie: got done=%b to=%b cnt=%0d expected 1 0 64", done, timeout, cycle_cnt);
                else passes++;
            end
        end
    endtask

    task automatic test_mid_reset_restart();
        logic gap_v [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        begin_run();
        for (int k = 1; k <= 10; k++) begin
            run_cycle(k == 5, 2'b11, {32'h7000 + 32'(8 * k), 32'h6000 + 32'(4 * k)});
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL mid_run k=%0d: got %h expected %h", k, dut_vec, exp_vec());
            else passes++;
            if (k == 5) begin
                checks++;
                if (running !== 1'b1 || cycle_cnt !== CW'(5))
                    $display("FAIL start_in_run: got running=%b cnt=%0d expected 1 5", running, cycle_cnt);
                else passes++;
            end
        end
        reset = 1'b0;
        run_cycle(1'b0, 2'b11, {32'h0, 32'h1});
        checks++;
        if (dut_vec !== RST_VEC) $display("FAIL mid_reset: got %h expected %h", dut_vec, RST_VEC);
        else passes++;
        reset = 1'b1;
        begin_run();
        for (int k = 1; k <= 9; k++) begin
            logic [31:0] p0;
            p0 = gap_v[k-1] ? 32'h4444 : $urandom;
            run_cycle(1'b0, {1'b1, gap_v[k-1]}, {32'h0, p0});
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL gaps k=%0d: got %h expected %h", k, dut_vec, exp_vec());
            else passes++;
            if (k == 7 || k == 8) begin
                checks++;
                if (halted[0] !== (k == 8))
                    $display("FAIL gap_halt k=%0d: got %b expected %b", k, halted[0], (k == 8));
                else passes++;
            end
        end
        checks++;
        if (done !== 1'b1) $display("FAIL gap_done: got %b expected 1", done);
        else passes++;
        run_cycle(1'b1, '0, '0);
        checks++;
        if (dut_vec !== RST_VEC) $display("FAIL restart_clear: got %h expected %h", dut_vec, RST_VEC);
        else passes++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_halt();
        test_two_cores();
        test_timeout();
        test_halt_at_limit();
        test_mid_reset_restart();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
